// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: HALT / RUN / STEP / BREAK with breakpoint.
// Ports: clk, rst (sync, active-high), run/halt/step requests,
//   bp_en/bp_addr/pc; cpu_en strobe, state, halted, step_cnt.
module td4_exec_ctrl #(
  parameter int unsigned DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] pc,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       halted,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } st_t;

  localparam logic [26:0] DIV_M1 = 27'(DIV - 1);

  st_t         st_q, st_n;
  logic [26:0] div_q, div_n;
  logic        skip_q, skip_n;
  logic        en_n;
  logic        bp_hit;

  assign bp_hit = bp_en && (pc == bp_addr);

  always_comb begin
    st_n   = st_q;
    div_n  = div_q;
    skip_n = skip_q;
    en_n   = 1'b0;
    unique case (st_q)
      S_HALT, S_BRK: begin
        if (halt_req) begin
          st_n   = S_HALT;
          skip_n = 1'b0;
        end else if (run_req) begin
          st_n   = S_RUN;
          div_n  = '0;
          // resuming from a breakpoint must step past it once
          skip_n = (st_q == S_BRK);
        end else if (step_req) begin
          st_n = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          st_n   = S_HALT;
          div_n  = '0;
          skip_n = 1'b0;
        end else if (div_q == DIV_M1) begin
          div_n = '0;
          if (bp_hit && !skip_q) begin
            st_n = S_BRK;
          end else begin
            en_n   = 1'b1;
            skip_n = 1'b0;
          end
        end else begin
          div_n = div_q + 27'd1;
        end
      end
      S_STEP: begin
        st_n   = S_HALT;
        skip_n = 1'b0;
        en_n   = !halt_req;
      end
      default: st_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_HALT;
      div_q    <= '0;
      skip_q   <= 1'b0;
      cpu_en   <= 1'b0;
      halted   <= 1'b1;
      step_cnt <= '0;
    end else begin
      st_q     <= st_n;
      div_q    <= div_n;
      skip_q   <= skip_n;
      cpu_en   <= en_n;
      halted   <= (st_n == S_HALT) || (st_n == S_BRK);
      step_cnt <= step_cnt + {7'd0, en_n};
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed bench for td4_exec_ctrl with DIV=4.
// Inputs change #1 after posedge; outputs sampled there.
module tb_td4_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_req, halt_req, step_req;
  logic       bp_en;
  logic [3:0] bp_addr, pc;
  logic       cpu_en;
  logic [1:0] state;
  logic       halted;
  logic [7:0] step_cnt;

  int errs = 0;
  int chks = 0;
  int exp_cnt = 0;

  td4_exec_ctrl #(.DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_req  (run_req),
    .halt_req (halt_req),
    .step_req (step_req),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .state    (state),
    .halted   (halted),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    chks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    tick(1);
    run_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run_req = 1'b1;
    halt_req = 1'b1;
    step_req = 1'b1;
    bp_en = 1'b0;
    bp_addr = 4'd5;
    pc = 4'd0;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_halted", halted, 1);
    chk("rst_en", cpu_en, 0);
    chk("rst_cnt", step_cnt, 0);
    rst = 1'b0;
    run_req = 1'b0;
    halt_req = 1'b0;
    step_req = 1'b0;
    tick(1);
    chk("idle_state", state, 0);

    // free run: strobe after every 4th cycle in RUN
    pulse_run();
    chk("run_state", state, 1);
    chk("run_halted", halted, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk($sformatf("run_en%0d", k), cpu_en, (k % 4 == 0) ? 1 : 0);
    end
    exp_cnt = 3;
    chk("run_cnt", step_cnt, exp_cnt);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("halt_state", state, 0);
    chk("halt_halted", halted, 1);
    chk("halt_en", cpu_en, 0);

    // single step
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    chk("step_state", state, 2);
    chk("step_en0", cpu_en, 0);
    tick(1);
    exp_cnt++;
    chk("step_back", state, 0);
    chk("step_en1", cpu_en, 1);
    chk("step_cnt", step_cnt, exp_cnt);
    tick(1);
    chk("step_en2", cpu_en, 0);

    // halt on step entry cycle cancels the strobe
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("stepc_state", state, 0);
    chk("stepc_en", cpu_en, 0);
    chk("stepc_cnt", step_cnt, exp_cnt);

    // priority halt over run
    halt_req = 1'b1;
    run_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    run_req = 1'b0;
    chk("prio_state", state, 0);

    // halt in RUN at div_cnt==3
    pulse_run();
    tick(3);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("hrun_state", state, 0);
    chk("hrun_en", cpu_en, 0);
    tick(1);
    chk("hrun_en2", cpu_en, 0);
    chk("hrun_cnt", step_cnt, exp_cnt);

    // breakpoint
    bp_en = 1'b1;
    pc = 4'd5;
    pulse_run();
    tick(4);
    chk("bp_state", state, 3);
    chk("bp_halted", halted, 1);
    chk("bp_en", cpu_en, 0);
    chk("bp_cnt", step_cnt, exp_cnt);
    pulse_run();
    tick(4);
    exp_cnt++;
    chk("skip_en", cpu_en, 1);
    chk("skip_state", state, 1);
    chk("skip_cnt", step_cnt, exp_cnt);
    pc = 4'd6;
    tick(4);
    exp_cnt++;
    chk("nobp_en", cpu_en, 1);
    chk("nobp_state", state, 1);
    pc = 4'd5;
    tick(4);
    chk("rebp_state", state, 3);
    chk("rebp_en", cpu_en, 0);
    chk("rebp_cnt", step_cnt, exp_cnt);
    // step from BREAK ignores the breakpoint
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    chk("bstep_state", state, 2);
    tick(1);
    exp_cnt++;
    chk("bstep_en", cpu_en, 1);
    chk("bstep_cnt", step_cnt, exp_cnt);
    bp_en = 1'b0;

    // wrap after 256 strobes from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("wrst_cnt", step_cnt, 0);
    pulse_run();
    tick(1023);
    chk("wrap_255", step_cnt, 255);
    tick(1);
    chk("wrap_0", step_cnt, 0);
    chk("wrap_en", cpu_en, 1);
    // reset with a strobe pending at div_cnt==3
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rrun_en", cpu_en, 0);
    chk("rrun_state", state, 0);
    chk("rrun_halted", halted, 1);
    rst = 1'b0;
    tick(1);
    chk("rrun_en2", cpu_en, 0);
    chk("rrun_cnt", step_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
